inst_rom_loader: RTL and testbench

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

---
 rtl/inst_rom_loader.sv | 126 ++++++++++++
 tb/tb_inst_rom_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-stream program loader: bytes assemble big-endian
// into 32-bit words; the optional byte checksum is enabled by LOAD_CHECKSUM_EN.
module inst_rom_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  input  logic        load_end,
  output logic        load_done,
  output logic        busy,
  output logic [7:0]  checksum
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [1:0]        bidx;
  logic [31:0]       shift_word;
  logic [31:0]       merged;
  logic              accept;
  logic [31:0]       mem [DEPTH];

  assign accept     = (state == LOAD) && load_valid;
  assign load_ready = (state == LOAD) && !rst;
  assign busy       = ((state == LOAD) || (state == FLUSH)) && !rst;

  // Fetch port: out-of-range addresses and fetches during a load read as zero
  assign inst = (ce && !busy && !rst && ((addr >> (ADDR_W + 2)) == 32'd0))
                ? mem[addr[ADDR_W+1:2]] : 32'h0;

  // Place the incoming byte at its big-endian lane
  always_comb begin
    merged = shift_word;
    unique case (bidx)
      2'd0: merged[31:24] = load_byte;
      2'd1: merged[23:16] = load_byte;
      2'd2: merged[15:8]  = load_byte;
      2'd3: merged[7:0]   = load_byte;
    endcase
  end

  // Loader FSM; the memory array itself is never reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      bidx       <= 2'd0;
      shift_word <= 32'h0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (load_start) begin
            state      <= LOAD;
            wptr       <= '0;
            bidx       <= 2'd0;
            shift_word <= 32'h0;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (accept) begin
            if (bidx == 2'd3) begin
              mem[wptr]  <= merged;
              wptr       <= wptr + ADDR_W'(1);
              bidx       <= 2'd0;
              shift_word <= 32'h0;
            end else begin
              bidx       <= bidx + 2'd1;
              shift_word <= merged;
            end
          end
          // A full memory wins over a simultaneous load_end
          if (accept && (bidx == 2'd3) && (wptr == '1)) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else if (load_end) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (bidx != 2'd0) begin
            mem[wptr] <= shift_word;
            wptr      <= wptr + ADDR_W'(1);
          end
          bidx       <= 2'd0;
          shift_word <= 32'h0;
          state      <= DONE;
          load_done  <= 1'b1;
        end
      endcase
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [7:0] sum;

  // Modulo-256 sum of accepted bytes, restarted on each new load
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= 8'h00;
    end else if (((state == IDLE) || (state == DONE)) && load_start) begin
      sum <= 8'h00;
    end else if (accept) begin
      sum <= sum + load_byte;
    end
  end

  assign checksum = sum;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: randomized loads against a word-level
// reference memory; expectations are queued and checked by a negedge monitor.
module tb_inst_rom_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned NB    = 4 * DEPTH;

  localparam int K_INST  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_READY = 2;
  localparam int K_CSUM  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] inst;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h0;
  logic        load_ready;
  logic        load_end = 1'b0;
  logic        load_done;
  logic        busy;
  logic [7:0]  checksum;

  inst_rom_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_ready(load_ready), .load_end(load_end), .load_done(load_done),
    .busy(busy), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [7:0]  done_q[$];
  logic [7:0]  bq[$];
  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic string kname(input int k);
    case (k)
      K_INST:  return "inst";
      K_BUSY:  return "busy";
      K_READY: return "load_ready";
      K_CSUM:  return "checksum";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_sig(input int k, input logic [31:0] v);
    chk_t c;
    c.kind = k;
    c.exp  = v;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drain queued expectations and match every load_done pulse
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] got;
    logic [7:0]  e;
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        K_INST:  got = inst;
        K_BUSY:  got = {31'd0, busy};
        K_READY: got = {31'd0, load_ready};
        K_CSUM:  got = {24'd0, checksum};
        default: got = 'x;
      endcase
      vectors++;
      if (got !== c.exp) begin
        miscompares++;
        $display("FAIL %s: got %h, want %h at %0t", kname(c.kind), got, c.exp, $time);
      end
    end
    if (load_done !== 1'b0) begin
      vectors++;
      if (done_q.size() == 0) begin
        miscompares++;
        $display("FAIL load_done: got %b with no load pending, want 0 at %0t", load_done, $time);
      end else begin
        e = done_q.pop_front();
        if (checksum !== e) begin
          miscompares++;
          $display("FAIL done_checksum: got %h, want %h at %0t", checksum, e, $time);
        end
      end
    end
  end

  // Reference: accepted bytes fill words from 0, last partial word zero-padded
  function automatic logic [7:0] model_load(input int n_words_max);
    int         acc;
    logic [7:0] s;
    logic [31:0] w;
    acc = (bq.size() > NB) ? NB : bq.size();
    s = 8'h00;
    for (int i = 0; i < acc; i++) s = s + bq[i];
    for (int wi = 0; wi < (acc + 3) / 4 && wi < n_words_max; wi++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4 * wi + j < acc) w = w | (32'(bq[4 * wi + j]) << (24 - 8 * j));
      model_mem[wi] = w;
      known[wi] = 1'b1;
    end
`ifdef LOAD_CHECKSUM_EN
    return s;
`else
    return 8'h00;
`endif
  endfunction

  task automatic run_load(input bit use_end, input int max_gap, input bit extra);
    logic [7:0] s;
    s = model_load(DEPTH);
    done_q.push_back(s);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ce   = 1'b1;
    addr = {26'd0, 4'($urandom), 2'($urandom)};
    expect_sig(K_BUSY, 32'd1);
    expect_sig(K_READY, 32'd1);
    expect_sig(K_INST, 32'h0);
    for (int i = 0; i < bq.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      load_valid = 1'b1;
      load_byte  = bq[i];
      load_end   = use_end && (i == bq.size() - 1);
      tick();
      load_valid = 1'b0;
      load_end   = 1'b0;
    end
    ce = 1'b0;
    if (extra) begin
      load_valid = 1'b1;
      load_byte  = 8'($urandom);
      expect_sig(K_READY, 32'd0);
      tick();
      load_valid = 1'b0;
    end
    repeat (3) tick();
    expect_sig(K_BUSY, 32'd0);
    expect_sig(K_CSUM, {24'd0, s});
    tick();
  endtask

  task automatic fetch(input logic en, input logic [31:0] a, input logic [31:0] e);
    ce   = en;
    addr = a;
    expect_sig(K_INST, e);
    tick();
    ce = 1'b0;
  endtask

  task automatic fetch_all();
    for (int w = 0; w < DEPTH; w++)
      if (known[w]) fetch(1'b1, (32'(w) << 2) | 32'($urandom_range(0, 3)), model_mem[w]);
    fetch(1'b0, 32'($urandom_range(0, NB - 1)), 32'h0);
    fetch(1'b1, (32'd1 << $urandom_range(AW + 2, 31)) | 32'($urandom_range(0, NB - 1)), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] old1;
    for (int w = 0; w < DEPTH; w++) known[w] = 1'b0;

    // Reset: outputs quiet while rst is high and after release
    rst = 1'b1;
    tick();
    tick();
    ce = 1'b1;
    expect_sig(K_BUSY, 32'd0);
    expect_sig(K_READY, 32'd0);
    expect_sig(K_INST, 32'h0);
    expect_sig(K_CSUM, 32'h0);
    tick();
    ce  = 1'b0;
    rst = 1'b0;
    tick();
    expect_sig(K_BUSY, 32'd0);
    expect_sig(K_READY, 32'd0);
    expect_sig(K_CSUM, 32'h0);
    tick();

    // Exact word with load_end on the fourth byte
    bq = '{8'h34, 8'h01, 8'h00, 8'h0A};
    run_load(1'b1, 0, 1'b0);
    fetch(1'b1, 32'h0, 32'h3401000A);
    fetch(1'b1, 32'h3, 32'h3401000A);

    // Partial word flushed with zero padding
    bq = '{8'hAA, 8'hBB};
    run_load(1'b1, 1, 1'b0);
    fetch(1'b1, 32'h0, 32'hAABB0000);

    // Checksum wraparound
    bq = '{8'hFF, 8'h02};
    run_load(1'b1, 0, 1'b0);
    fetch(1'b1, 32'h1, 32'hFF020000);

    // Fill the whole memory; the byte after the last is refused
    bq = {};
    for (int i = 0; i < NB; i++) bq.push_back(8'($urandom));
    run_load(1'b0, 1, 1'b1);
    fetch_all();

    // Random-length loads terminated by load_end
    for (int t = 0; t < 5; t++) begin
      bq = {};
      for (int i = 0, n = $urandom_range(1, NB); i < n; i++) bq.push_back(8'($urandom));
      run_load(1'b1, 2, 1'b0);
      fetch_all();
    end

    // Reset after six bytes: word 0 kept, partial word 1 dropped
    old1 = model_mem[1];
    bq = {};
    for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_byte  = bq[i];
      tick();
    end
    load_valid = 1'b0;
    model_mem[0] = {bq[0], bq[1], bq[2], bq[3]};
    rst = 1'b1;
    ce  = 1'b1;
    addr = 32'h0;
    expect_sig(K_BUSY, 32'd0);
    expect_sig(K_READY, 32'd0);
    expect_sig(K_INST, 32'h0);
    tick();
    rst = 1'b0;
    ce  = 1'b0;
    expect_sig(K_BUSY, 32'd0);
    expect_sig(K_CSUM, 32'h0);
    tick();
    fetch(1'b1, 32'h4, old1);
    fetch(1'b1, 32'h0, model_mem[0]);

    repeat (3) tick();
    vectors++;
    if (done_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_done: got %0d load_done pulses missing, want 0", done_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
